// File: rtl/pipe_control_unit_pkg.sv
// Shared types and constants for the pipelined ARM-subset controller.
//   ctrl_bundle_t : control bundle carried from Decode into Execute
//   cond_e        : ARM condition-field encodings (EQ..AL, NV executes as AL)
//   OP_*/CMD_*    : instruction Op and DP cmd encodings
//   ALU_*         : ALUControl operation codes
//   cond_pass     : condition field evaluated against NZCV
package pipe_ctrl_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  typedef struct packed {
    logic       RegW;
    logic       MemW;
    logic       MemtoReg;
    logic       ALUSrc;
    logic       Branch;
    logic       PCS;
    logic [1:0] FlagW;      // [1] = NZ, [0] = CV
    logic [2:0] ALUControl;
  } ctrl_bundle_t;

  function automatic int unsigned alucontrol_w(input bit ext_ops);
    return ext_ops ? 32'd3 : 32'd2;
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    case (cond_e'(cond))
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      default: r = 1'b1;    // AL and 4'hF
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_control_unit_if.sv
// Controller <-> datapath/hazard-unit signal bundle.
//   master : datapath side (drives InstrD, ALUFlagsE, FlushE)
//   slave  : controller side (drives all decode/stage control outputs)
interface pipe_control_unit_if #(
  parameter int unsigned ALUCONTROL_W = 3
);
  logic [19:0]             InstrD;
  logic [3:0]              ALUFlagsE;
  logic                    FlushE;
  logic [1:0]              RegSrcD;
  logic [1:0]              ImmSrcD;
  logic                    LinkD;
  logic                    IllegalD;
  logic                    ALUSrcE;
  logic [ALUCONTROL_W-1:0] ALUControlE;
  logic                    BranchTakenE;
  logic                    MemtoRegE;
  logic                    MemWriteM;
  logic                    RegWriteM;
  logic                    MemtoRegW;
  logic                    RegWriteW;
  logic                    PCSrcW;
  logic                    PCWrPendingF;

  modport master (
    output InstrD, ALUFlagsE, FlushE,
    input  RegSrcD, ImmSrcD, LinkD, IllegalD, ALUSrcE, ALUControlE, BranchTakenE,
           MemtoRegE, MemWriteM, RegWriteM, MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF
  );

  modport slave (
    input  InstrD, ALUFlagsE, FlushE,
    output RegSrcD, ImmSrcD, LinkD, IllegalD, ALUSrcE, ALUControlE, BranchTakenE,
           MemtoRegE, MemWriteM, RegWriteM, MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF
  );
endinterface

// File: rtl/pipe_control_unit_cond.sv
// Execute-stage condition logic: NZCV flag register, condition evaluation
// and gating of the side-effect enables of the instruction in Execute.
//   clk_i, reset_i   : clock, synchronous active-high reset
//   cond_i           : Cond field of the Execute instruction
//   flag_w_i         : flag-write request {NZ, CV}
//   alu_flags_i      : NZCV from the ALU
//   reg_w_i/mem_w_i/pcs_i/branch_i : ungated enables
//   reg_write_o/mem_write_o/pc_src_o/branch_taken_o : condition-gated enables
module pipe_cond_logic import pipe_ctrl_pkg::*; #(
  parameter bit EN_COND = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] cond_i,
  input  logic [1:0] flag_w_i,
  input  logic [3:0] alu_flags_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  input  logic       pcs_i,
  input  logic       branch_i,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       pc_src_o,
  output logic       branch_taken_o
);
  logic [3:0] flags_q, flags_d;
  logic       cond_ex;

  // Evaluated on the registered flags: an instruction never sees the
  // update made by its own-cycle predecessor until the next edge.
  assign cond_ex = EN_COND ? cond_pass(cond_i, flags_q) : 1'b1;

  always_comb begin
    flags_d = flags_q;
    if (flag_w_i[1] & cond_ex) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_w_i[0] & cond_ex) flags_d[1:0] = alu_flags_i[1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) flags_q <= '0;
    else         flags_q <= flags_d;
  end

  assign reg_write_o    = reg_w_i  & cond_ex;
  assign mem_write_o    = mem_w_i  & cond_ex;
  assign pc_src_o       = pcs_i    & cond_ex;
  assign branch_taken_o = branch_i & cond_ex;
endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined controller for the 5-stage ARM-subset core.
//   clk, reset : clock, synchronous active-high reset
//   ctrl       : slave side of pipe_control_unit_if (InstrD/ALUFlagsE/FlushE in,
//                Decode, Execute, Memory and Writeback control out)
// Decode is combinational; D->E is bubbled by reset or FlushE; E->M and M->W
// always advance. Unsupported instructions decode to an all-zero bundle.
module pipe_control_unit import pipe_ctrl_pkg::*; #(
  parameter bit EN_EXT_OPS = 1'b1,
  parameter bit EN_BL      = 1'b1,
  parameter bit EN_COND    = 1'b1
) (
  input logic                clk,
  input logic                reset,
  pipe_control_unit_if.slave ctrl
);
  localparam int unsigned ALUCONTROL_W = alucontrol_w(EN_EXT_OPS);

  logic [3:0]   cond_d, rd_d, cmd_d;
  logic [1:0]   op_d, regsrc_d, immsrc_d;
  logic [5:0]   funct_d;
  logic         s_d, link_d, illegal_d, arith_d;
  ctrl_bundle_t bun_d, bun_e_q;
  logic [3:0]   cond_e_q;
  logic         regw_e_g, memw_e_g, pcs_e_g, branch_taken_e;
  logic         regw_m_q, memw_m_q, mtr_m_q, pcs_m_q;
  logic         regw_w_q, mtr_w_q, pcs_w_q;
  logic         unused_bits;

  assign cond_d  = ctrl.InstrD[19:16];
  assign op_d    = ctrl.InstrD[15:14];
  assign funct_d = ctrl.InstrD[13:8];
  assign rd_d    = ctrl.InstrD[3:0];
  assign cmd_d   = funct_d[4:1];
  assign s_d     = funct_d[0];
  // Rn is not needed by the controller; ALUControl[2] is constant 0 when EN_EXT_OPS=0.
  assign unused_bits = ^{ctrl.InstrD[7:4], bun_e_q.ALUControl};

  always_comb begin
    bun_d     = '0;
    regsrc_d  = 2'b00;
    immsrc_d  = 2'b00;
    link_d    = 1'b0;
    illegal_d = 1'b0;
    arith_d   = 1'b0;
    case (op_d)
      OP_DP: begin
        bun_d.RegW   = 1'b1;
        bun_d.ALUSrc = funct_d[5];
        case (cmd_d)
          CMD_ADD: begin bun_d.ALUControl = ALU_ADD; arith_d = 1'b1; end
          CMD_SUB: begin bun_d.ALUControl = ALU_SUB; arith_d = 1'b1; end
          CMD_AND: bun_d.ALUControl = ALU_AND;
          CMD_ORR: bun_d.ALUControl = ALU_ORR;
          CMD_EOR: if (EN_EXT_OPS) bun_d.ALUControl = ALU_EOR; else illegal_d = 1'b1;
          CMD_MOV: if (EN_EXT_OPS) bun_d.ALUControl = ALU_MOV; else illegal_d = 1'b1;
          CMD_CMP: begin
            if (EN_EXT_OPS) begin
              bun_d.ALUControl = ALU_SUB;
              bun_d.RegW       = 1'b0;
              arith_d          = 1'b1;
            end else begin
              illegal_d = 1'b1;
            end
          end
          default: illegal_d = 1'b1;
        endcase
        bun_d.FlagW = {s_d, s_d & arith_d};
        // An unsupported cmd must leave no side effect anywhere downstream.
        if (illegal_d) bun_d = '0;
      end
      OP_MEM: begin
        bun_d.ALUSrc = 1'b1;
        immsrc_d     = 2'b01;
        if (funct_d[0]) begin
          bun_d.RegW     = 1'b1;
          bun_d.MemtoReg = 1'b1;
        end else begin
          bun_d.MemW = 1'b1;
          regsrc_d   = 2'b10;
        end
      end
      OP_BR: begin
        bun_d.ALUSrc = 1'b1;
        bun_d.Branch = 1'b1;
        immsrc_d     = 2'b10;
        regsrc_d     = 2'b01;
        if (EN_BL && funct_d[4]) begin
          bun_d.RegW = 1'b1;
          link_d     = 1'b1;
        end
      end
      default: illegal_d = 1'b1;
    endcase
    bun_d.PCS = ((rd_d == 4'hF) & bun_d.RegW) | bun_d.Branch;
  end

  always_ff @(posedge clk) begin
    if (reset || ctrl.FlushE) begin
      bun_e_q  <= '0;
      cond_e_q <= '0;
    end else begin
      bun_e_q  <= bun_d;
      cond_e_q <= cond_d;
    end
  end

  pipe_cond_logic #(.EN_COND(EN_COND)) u_cond (
    .clk_i          (clk),
    .reset_i        (reset),
    .cond_i         (cond_e_q),
    .flag_w_i       (bun_e_q.FlagW),
    .alu_flags_i    (ctrl.ALUFlagsE),
    .reg_w_i        (bun_e_q.RegW),
    .mem_w_i        (bun_e_q.MemW),
    .pcs_i          (bun_e_q.PCS),
    .branch_i       (bun_e_q.Branch),
    .reg_write_o    (regw_e_g),
    .mem_write_o    (memw_e_g),
    .pc_src_o       (pcs_e_g),
    .branch_taken_o (branch_taken_e)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      regw_m_q <= 1'b0;
      memw_m_q <= 1'b0;
      mtr_m_q  <= 1'b0;
      pcs_m_q  <= 1'b0;
      regw_w_q <= 1'b0;
      mtr_w_q  <= 1'b0;
      pcs_w_q  <= 1'b0;
    end else begin
      regw_m_q <= regw_e_g;
      memw_m_q <= memw_e_g;
      mtr_m_q  <= bun_e_q.MemtoReg;
      pcs_m_q  <= pcs_e_g;
      regw_w_q <= regw_m_q;
      mtr_w_q  <= mtr_m_q;
      pcs_w_q  <= pcs_m_q;
    end
  end

  assign ctrl.RegSrcD      = regsrc_d;
  assign ctrl.ImmSrcD      = immsrc_d;
  assign ctrl.LinkD        = link_d;
  assign ctrl.IllegalD     = illegal_d;
  assign ctrl.ALUSrcE      = bun_e_q.ALUSrc;
  assign ctrl.ALUControlE  = bun_e_q.ALUControl[ALUCONTROL_W-1:0];
  assign ctrl.BranchTakenE = branch_taken_e;
  assign ctrl.MemtoRegE    = bun_e_q.MemtoReg;
  assign ctrl.MemWriteM    = memw_m_q;
  assign ctrl.RegWriteM    = regw_m_q;
  assign ctrl.MemtoRegW    = mtr_w_q;
  assign ctrl.RegWriteW    = regw_w_q;
  assign ctrl.PCSrcW       = pcs_w_q;
  assign ctrl.PCWrPendingF = bun_d.PCS | pcs_e_g | pcs_m_q;
endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: two instances (full feature set,
// and EN_EXT_OPS=0/EN_BL=0/EN_COND=0) driven with the same stream and checked
// against a mnemonic-level pipeline model.
module tb_pipe_control_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_control_unit_if #(.ALUCONTROL_W(3)) if0 ();
  pipe_control_unit_if #(.ALUCONTROL_W(2)) if1 ();

  pipe_control_unit #(.EN_EXT_OPS(1'b1), .EN_BL(1'b1), .EN_COND(1'b1)) dut0 (
    .clk(clk), .reset(reset), .ctrl(if0));
  pipe_control_unit #(.EN_EXT_OPS(1'b0), .EN_BL(1'b0), .EN_COND(1'b0)) dut1 (
    .clk(clk), .reset(reset), .ctrl(if1));

  bit cfg_ext  [2] = '{1'b1, 1'b0};
  bit cfg_bl   [2] = '{1'b1, 1'b0};
  bit cfg_cond [2] = '{1'b1, 1'b0};

  typedef enum int {M_ADD, M_SUB, M_AND, M_ORR, M_EOR, M_CMP, M_MOV,
                    M_LDR, M_STR, M_B, M_BL, M_BAD} mn_e;

  typedef struct {
    bit regw, memw, load, alusrc, branch, pcw, link, illegal, nz, cv;
    int alu;
    bit [3:0] cond;
    bit [1:0] regsrc, immsrc;
  } dec_t;

  typedef struct {
    logic [1:0] regsrc, immsrc;
    logic link, illegal, alusrc;
    logic [2:0] aluctl;
    logic btaken, mtrE, memwM, regwM, mtrW, regwW, pcsW, pend;
    logic [3:0] flags;
  } obs_t;

  dec_t     st_e [2];
  dec_t     st_m [2];
  dec_t     st_w [2];
  bit [3:0] mflags [2];
  dec_t     zd;
  obs_t     q0[$];
  obs_t     q1[$];
  int       n_vec = 0;
  int       n_bad = 0;

  function automatic dec_t mdecode(int k, logic [19:0] ins);
    dec_t d = zd;
    mn_e m;
    logic [1:0] op = ins[15:14];
    logic [5:0] f  = ins[13:8];
    d.cond = ins[19:16];
    case (op)
      2'd0: case (f[4:1])
              4'd4:  m = M_ADD;
              4'd2:  m = M_SUB;
              4'd0:  m = M_AND;
              4'd12: m = M_ORR;
              4'd1:  m = cfg_ext[k] ? M_EOR : M_BAD;
              4'd10: m = cfg_ext[k] ? M_CMP : M_BAD;
              4'd13: m = cfg_ext[k] ? M_MOV : M_BAD;
              default: m = M_BAD;
            endcase
      2'd1: m = f[0] ? M_LDR : M_STR;
      2'd2: m = (f[4] && cfg_bl[k]) ? M_BL : M_B;
      default: m = M_BAD;
    endcase
    if (m == M_BAD) begin
      d.illegal = 1'b1;
      return d;
    end
    d.branch = (m == M_B) || (m == M_BL);
    d.link   = (m == M_BL);
    d.load   = (m == M_LDR);
    d.memw   = (m == M_STR);
    d.regw   = (m <= M_MOV && m != M_CMP) || m == M_LDR || m == M_BL;
    d.alusrc = (m <= M_MOV) ? f[5] : 1'b1;
    case (m)
      M_SUB, M_CMP: d.alu = 1;
      M_AND: d.alu = 2;
      M_ORR: d.alu = 3;
      M_EOR: d.alu = 4;
      M_MOV: d.alu = 5;
      default: d.alu = 0;
    endcase
    d.nz     = (m <= M_MOV) && f[0];
    d.cv     = f[0] && (m == M_ADD || m == M_SUB || m == M_CMP);
    d.pcw    = (ins[3:0] == 4'hF && d.regw) || d.branch;
    d.regsrc = (m == M_STR) ? 2'b10 : (d.branch ? 2'b01 : 2'b00);
    d.immsrc = (m == M_LDR || m == M_STR) ? 2'b01 : (d.branch ? 2'b10 : 2'b00);
    return d;
  endfunction

  // Odd codes are the negation of the even code below them; code 7 pair is always.
  function automatic bit mpass(int k, bit [3:0] c, bit [3:0] fl);
    bit n = fl[3], z = fl[2], cy = fl[1], v = fl[0], base;
    if (!cfg_cond[k]) return 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic obs_t mexpect(int k, logic [19:0] ins);
    obs_t x;
    dec_t d = mdecode(k, ins);
    bit p = mpass(k, st_e[k].cond, mflags[k]);
    x.regsrc  = d.regsrc;
    x.immsrc  = d.immsrc;
    x.link    = d.link;
    x.illegal = d.illegal;
    x.alusrc  = st_e[k].alusrc;
    x.aluctl  = 3'(st_e[k].alu);
    x.btaken  = st_e[k].branch && p;
    x.mtrE    = st_e[k].load;
    x.memwM   = st_m[k].memw;
    x.regwM   = st_m[k].regw;
    x.mtrW    = st_w[k].load;
    x.regwW   = st_w[k].regw;
    x.pcsW    = st_w[k].pcw;
    x.pend    = d.pcw || (st_e[k].pcw && p) || st_m[k].pcw;
    x.flags   = mflags[k];
    return x;
  endfunction

  task automatic mstep(int k, logic rst, logic [19:0] ins, logic [3:0] af, logic fl);
    bit p;
    if (rst) begin
      st_e[k] = zd; st_m[k] = zd; st_w[k] = zd; mflags[k] = 4'h0;
      return;
    end
    p = mpass(k, st_e[k].cond, mflags[k]);
    if (st_e[k].nz && p) mflags[k][3:2] = af[3:2];
    if (st_e[k].cv && p) mflags[k][1:0] = af[1:0];
    st_w[k] = st_m[k];
    st_m[k] = st_e[k];
    st_m[k].regw = st_e[k].regw && p;
    st_m[k].memw = st_e[k].memw && p;
    st_m[k].pcw  = st_e[k].pcw && p;
    st_e[k] = fl ? zd : mdecode(k, ins);
  endtask

  task automatic cyc(input logic rst, input logic [19:0] ins, input logic [3:0] af, input logic fl);
    @(negedge clk);
    reset = rst;
    if0.InstrD = ins; if0.ALUFlagsE = af; if0.FlushE = fl;
    if1.InstrD = ins; if1.ALUFlagsE = af; if1.FlushE = fl;
    q0.push_back(mexpect(0, ins));
    q1.push_back(mexpect(1, ins));
    mstep(0, rst, ins, af, fl);
    mstep(1, rst, ins, af, fl);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_obs(input string who, input obs_t a, input obs_t e);
    chk({who, ".RegSrcD"},      8'(a.regsrc),  8'(e.regsrc));
    chk({who, ".ImmSrcD"},      8'(a.immsrc),  8'(e.immsrc));
    chk({who, ".LinkD"},        8'(a.link),    8'(e.link));
    chk({who, ".IllegalD"},     8'(a.illegal), 8'(e.illegal));
    chk({who, ".ALUSrcE"},      8'(a.alusrc),  8'(e.alusrc));
    chk({who, ".ALUControlE"},  8'(a.aluctl),  8'(e.aluctl));
    chk({who, ".BranchTakenE"}, 8'(a.btaken),  8'(e.btaken));
    chk({who, ".MemtoRegE"},    8'(a.mtrE),    8'(e.mtrE));
    chk({who, ".MemWriteM"},    8'(a.memwM),   8'(e.memwM));
    chk({who, ".RegWriteM"},    8'(a.regwM),   8'(e.regwM));
    chk({who, ".MemtoRegW"},    8'(a.mtrW),    8'(e.mtrW));
    chk({who, ".RegWriteW"},    8'(a.regwW),   8'(e.regwW));
    chk({who, ".PCSrcW"},       8'(a.pcsW),    8'(e.pcsW));
    chk({who, ".PCWrPendingF"}, 8'(a.pend),    8'(e.pend));
    chk({who, ".FlagsQ"},       8'(a.flags),   8'(e.flags));
  endtask

  obs_t ex0, ex1, a0, a1;

  always @(negedge clk) begin
    #2;
    if (q0.size() > 0 && q1.size() > 0) begin
      ex0 = q0.pop_front();
      ex1 = q1.pop_front();
      a0 = '{if0.RegSrcD, if0.ImmSrcD, if0.LinkD, if0.IllegalD, if0.ALUSrcE, if0.ALUControlE,
             if0.BranchTakenE, if0.MemtoRegE, if0.MemWriteM, if0.RegWriteM, if0.MemtoRegW,
             if0.RegWriteW, if0.PCSrcW, if0.PCWrPendingF, dut0.u_cond.flags_q};
      a1 = '{if1.RegSrcD, if1.ImmSrcD, if1.LinkD, if1.IllegalD, if1.ALUSrcE, {1'b0, if1.ALUControlE},
             if1.BranchTakenE, if1.MemtoRegE, if1.MemWriteM, if1.RegWriteM, if1.MemtoRegW,
             if1.RegWriteW, if1.PCSrcW, if1.PCWrPendingF, dut1.u_cond.flags_q};
      cmp_obs("full", a0, ex0);
      cmp_obs("min", a1, ex1);
    end
  end

  function automatic logic [19:0] mk(logic [3:0] c, logic [1:0] op, logic [5:0] f, logic [3:0] rd);
    return {c, op, f, 4'h0, rd};
  endfunction

  initial begin
    logic [19:0] nop, adds, cmp, beq, bne, str_eq, ldr, bl, ill, mov, addpc, ins;
    logic [3:0]  af;
    nop    = mk(4'hE, 2'b00, 6'b001000, 4'h0);
    adds   = mk(4'hE, 2'b00, 6'b101001, 4'h1);
    cmp    = mk(4'hE, 2'b00, 6'b110101, 4'h0);
    beq    = mk(4'h0, 2'b10, 6'b000000, 4'h5);
    bne    = mk(4'h1, 2'b10, 6'b000000, 4'h5);
    str_eq = mk(4'h0, 2'b01, 6'b011000, 4'h2);
    ldr    = mk(4'hE, 2'b01, 6'b011001, 4'h3);
    bl     = mk(4'hE, 2'b10, 6'b010000, 4'h0);
    ill    = mk(4'hE, 2'b11, 6'b111111, 4'hF);
    mov    = mk(4'hE, 2'b00, 6'b111010, 4'h3);
    addpc  = mk(4'hE, 2'b00, 6'b001000, 4'hF);

    reset = 1'b1;
    if0.InstrD = '0; if0.ALUFlagsE = '0; if0.FlushE = 1'b0;
    if1.InstrD = '0; if1.ALUFlagsE = '0; if1.FlushE = 1'b0;

    cyc(1'b1, 20'($urandom), 4'($urandom), 1'b0);
    cyc(1'b1, 20'($urandom), 4'($urandom), 1'b1);

    cyc(1'b0, adds, 4'h0, 1'b0);
    cyc(1'b0, nop, 4'b0100, 1'b0);
    repeat (3) cyc(1'b0, nop, 4'h0, 1'b0);

    cyc(1'b0, cmp, 4'h0, 1'b0);
    cyc(1'b0, beq, 4'b0100, 1'b0);
    repeat (3) cyc(1'b0, nop, 4'h0, 1'b0);
    cyc(1'b0, cmp, 4'h0, 1'b0);
    cyc(1'b0, bne, 4'b0100, 1'b0);
    repeat (3) cyc(1'b0, nop, 4'h0, 1'b0);

    cyc(1'b0, cmp, 4'h0, 1'b0);
    cyc(1'b0, str_eq, 4'b0000, 1'b0);
    repeat (3) cyc(1'b0, nop, 4'h0, 1'b0);
    cyc(1'b0, cmp, 4'h0, 1'b0);
    cyc(1'b0, str_eq, 4'b0100, 1'b0);
    repeat (3) cyc(1'b0, nop, 4'h0, 1'b0);

    cyc(1'b0, ldr, 4'h0, 1'b1);
    repeat (3) cyc(1'b0, nop, 4'h0, 1'b0);
    cyc(1'b0, bl, 4'h0, 1'b0);
    repeat (3) cyc(1'b0, nop, 4'h0, 1'b0);
    cyc(1'b0, ill, 4'h0, 1'b0);
    cyc(1'b0, mov, 4'h0, 1'b0);
    cyc(1'b0, addpc, 4'h0, 1'b0);
    repeat (3) cyc(1'b0, nop, 4'h0, 1'b0);

    // flush alongside a flag-setting instruction in Execute
    cyc(1'b0, cmp, 4'h0, 1'b0);
    cyc(1'b0, nop, 4'b0100, 1'b1);
    cyc(1'b0, beq, 4'h0, 1'b0);
    repeat (2) cyc(1'b0, nop, 4'h0, 1'b0);

    // reset with writes in flight, then reset together with flush
    cyc(1'b0, adds, 4'h0, 1'b0);
    cyc(1'b0, ldr, 4'hF, 1'b0);
    cyc(1'b0, addpc, 4'h0, 1'b0);
    cyc(1'b1, str_eq, 4'h0, 1'b0);
    cyc(1'b0, bl, 4'h0, 1'b0);
    cyc(1'b1, ldr, 4'h0, 1'b1);
    repeat (3) cyc(1'b0, nop, 4'h0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      ins = 20'($urandom);
      if ($urandom_range(0, 1) == 0) ins[19:16] = 4'hE;
      af = 4'($urandom);
      cyc($urandom_range(0, 49) == 0, ins, af, $urandom_range(0, 7) == 0);
    end

    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
